// File: rtl/sprite_draw_scheduler_pkg.sv
// rtl/sprite_draw_scheduler_pkg.sv - shared states, origin widths and defaults for the sprite draw scheduler
package sprite_draw_scheduler_pkg;

    localparam int X_W                    = 8;
    localparam int Y_W                    = 9;
    localparam int ROMID_W                = 4;
    localparam int GRANT_W                = 3;
    localparam int DEFAULT_LAUNCH_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        LAUNCH = 2'd2,
        BUSY   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// rtl/sprite_draw_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts just above ptr
module rr_arbiter
    import sprite_draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] grant_idx
);

    logic               hi_found;
    logic [GRANT_W-1:0] hi_idx;
    logic [GRANT_W-1:0] lo_idx;

    // Lowest requester above ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = GRANT_W'(i);
                if (i > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = GRANT_W'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = (req != '0) && (grant_idx == GRANT_W'(i));
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// rtl/sprite_draw_scheduler.sv - shares one sprite draw engine between NUM_REQ requesters
module sprite_draw_scheduler
    import sprite_draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LAUNCH_TIMEOUT = DEFAULT_LAUNCH_TIMEOUT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           reqValid,
    input  logic [X_W*NUM_REQ-1:0]       reqX,
    input  logic [Y_W*NUM_REQ-1:0]       reqY,
    input  logic [ROMID_W*NUM_REQ-1:0]   reqROMId,
    output logic [NUM_REQ-1:0]           reqAck,
    output logic [NUM_REQ-1:0]           reqDone,
    output logic                         timeoutErr,
    output logic                         busy,
    output logic [GRANT_W-1:0]           grantId,
    input  logic                         drawerReady,
    output logic                         drawerDraw,
    output logic [X_W-1:0]               drawerX,
    output logic [Y_W-1:0]               drawerY,
    output logic [ROMID_W-1:0]           drawerROMId
);

    localparam int                 CNT_W    = $clog2(LAUNCH_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);
    localparam logic [GRANT_W-1:0] LAST_ID  = GRANT_W'(NUM_REQ - 1);

    sched_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] arb_grant, ack_d, done_d;
    logic [GRANT_W-1:0] arb_idx, grant_d;
    logic               terr_d, draw_d;
    logic [X_W-1:0]     sel_x, x_d;
    logic [Y_W-1:0]     sel_y, y_d;
    logic [ROMID_W-1:0] sel_rom, rom_d;

    // grantId doubles as the round-robin pointer.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (reqValid),
        .ptr       (grantId),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_rom = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_x   = reqX[i*X_W +: X_W];
                sel_y   = reqY[i*Y_W +: Y_W];
                sel_rom = reqROMId[i*ROMID_W +: ROMID_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = '0;
        terr_d  = 1'b0;
        draw_d  = 1'b0;
        grant_d = grantId;
        x_d     = drawerX;
        y_d     = drawerY;
        rom_d   = drawerROMId;
        case (state_q)
            IDLE: begin
                if ((reqValid != '0) && drawerReady) begin
                    ack_d   = arb_grant;
                    grant_d = arb_idx;
                    x_d     = sel_x;
                    y_d     = sel_y;
                    rom_d   = sel_rom;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                draw_d  = 1'b1;
                cnt_d   = '0;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                cnt_d  = cnt_q + CNT_W'(1);
                draw_d = 1'b1;
                if (!drawerReady) begin
                    draw_d  = 1'b0;
                    state_d = BUSY;
                end else if (cnt_q == CNT_LAST) begin
                    draw_d  = 1'b0;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (drawerReady) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        done_d[i] = (grantId == GRANT_W'(i));
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            reqAck      <= '0;
            reqDone     <= '0;
            timeoutErr  <= 1'b0;
            busy        <= 1'b0;
            grantId     <= LAST_ID;
            drawerDraw  <= 1'b0;
            drawerX     <= '0;
            drawerY     <= '0;
            drawerROMId <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reqAck      <= ack_d;
            reqDone     <= done_d;
            timeoutErr  <= terr_d;
            busy        <= (state_d != IDLE);
            grantId     <= grant_d;
            drawerDraw  <= draw_d;
            drawerX     <= x_d;
            drawerY     <= y_d;
            drawerROMId <= rom_d;
        end
    end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb/tb_sprite_draw_scheduler.sv - self-checking bench for sprite_draw_scheduler
module tb_sprite_draw_scheduler;

    localparam int N = 4;
    localparam int T = 16;

    logic           clock       = 1'b0;
    logic           reset       = 1'b1;
    logic [N-1:0]   reqValid    = '0;
    logic [8*N-1:0] reqX        = '0;
    logic [9*N-1:0] reqY        = '0;
    logic [4*N-1:0] reqROMId    = '0;
    logic           drawerReady = 1'b1;
    logic [N-1:0]   reqAck, reqDone;
    logic           timeoutErr, busy, drawerDraw;
    logic [2:0]     grantId;
    logic [7:0]     drawerX;
    logic [8:0]     drawerY;
    logic [3:0]     drawerROMId;

    sprite_draw_scheduler #(.NUM_REQ(N), .LAUNCH_TIMEOUT(T)) dut (
        .clock       (clock),
        .reset       (reset),
        .reqValid    (reqValid),
        .reqX        (reqX),
        .reqY        (reqY),
        .reqROMId    (reqROMId),
        .reqAck      (reqAck),
        .reqDone     (reqDone),
        .timeoutErr  (timeoutErr),
        .busy        (busy),
        .grantId     (grantId),
        .drawerReady (drawerReady),
        .drawerDraw  (drawerDraw),
        .drawerX     (drawerX),
        .drawerY     (drawerY),
        .drawerROMId (drawerROMId)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Engine: sees the strobe, drops ready one cycle later, stays busy draw_len cycles.
    int draw_len = 50;
    bit eng_hang = 1'b0;
    int eng_st   = 0;
    int eng_left = 0;
    always @(negedge clock) begin
        if (reset) begin
            eng_st      = 0;
            drawerReady = 1'b1;
        end else if (eng_st == 0) begin
            if (drawerDraw && !eng_hang) eng_st = 1;
        end else if (eng_st == 1) begin
            drawerReady = 1'b0;
            eng_left    = draw_len;
            eng_st      = 2;
        end else begin
            eng_left--;
            if (eng_left == 0) begin
                drawerReady = 1'b1;
                eng_st      = 0;
            end
        end
    end

    // Behavioural model: one job at a time, tracked by launch length and acceptance.
    int           cyc     = 0;
    bit           m_valid = 1'b0;
    logic [N-1:0] m_ack   = '0;
    logic [N-1:0] m_done  = '0;
    bit           m_terr  = 1'b0;
    bit           m_busy  = 1'b0;
    bit           m_draw  = 1'b0;
    int           m_gid   = N - 1;
    int           m_x = 0, m_y = 0, m_rom = 0;
    bit           job = 1'b0, accepted = 1'b0;
    int           lc  = 0;

    always @(posedge clock) begin : model
        logic [N-1:0]   v;
        logic [8*N-1:0] sx;
        logic [9*N-1:0] sy;
        logic [4*N-1:0] sr;
        logic           rdy, rst;
        int             w, c;
        v = reqValid; sx = reqX; sy = reqY; sr = reqROMId;
        rdy = drawerReady; rst = reset;
        cyc++;
        m_valid = 1'b1;
        m_ack = '0; m_done = '0; m_terr = 1'b0;
        if (rst) begin
            job = 1'b0; accepted = 1'b0; lc = 0; m_draw = 1'b0;
            m_x = 0; m_y = 0; m_rom = 0; m_gid = N - 1;
        end else if (!job) begin
            if (v != '0 && rdy) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_gid + k) % N;
                    if (w < 0 && v[c]) w = c;
                end
                m_ack[w] = 1'b1;
                m_gid = w;
                m_x = int'(sx[w*8 +: 8]);
                m_y = int'(sy[w*9 +: 9]);
                m_rom = int'(sr[w*4 +: 4]);
                job = 1'b1; accepted = 1'b0; lc = 0;
            end
        end else if (accepted) begin
            if (rdy) begin
                m_done[m_gid] = 1'b1;
                job = 1'b0;
            end
        end else if (lc == 0) begin
            m_draw = 1'b1;
            lc = 1;
        end else if (!rdy) begin
            m_draw = 1'b0;
            accepted = 1'b1;
        end else if (lc == T) begin
            m_draw = 1'b0;
            m_terr = 1'b1;
            job = 1'b0;
        end else begin
            lc++;
        end
        m_busy = job;
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("reqAck", reqAck, m_ack);
            chk("reqDone", reqDone, m_done);
            chk("timeoutErr", timeoutErr, m_terr);
            chk("busy", busy, m_busy);
            chk("grantId", grantId, m_gid);
            chk("drawerDraw", drawerDraw, m_draw);
            chk("drawerX", drawerX, m_x);
            chk("drawerY", drawerY, m_y);
            chk("drawerROMId", drawerROMId, m_rom);
        end
    end

    logic [N-1:0] rereq = '0;
    int last_ack_idx = -1, last_ack_cyc = 0, last_done_cyc = 0, terr_cyc = 0;
    int draw_cnt = 0, done_cnt = 0;
    int grants[$];

    task automatic set_fields(input int i, input int x, input int y, input int r);
        reqX[i*8 +: 8]     = 8'(x);
        reqY[i*9 +: 9]     = 9'(y);
        reqROMId[i*4 +: 4] = 4'(r);
    endtask

    task automatic tick();
        @(negedge clock);
        if (drawerDraw) draw_cnt++;
        if (timeoutErr) terr_cyc = cyc;
        for (int i = 0; i < N; i++) begin
            if (reqAck[i]) begin
                last_ack_idx = i;
                last_ack_cyc = cyc;
                grants.push_back(i);
                reqValid[i] = rereq[i];
                if (rereq[i]) reqX[i*8 +: 8] = reqX[i*8 +: 8] + 8'd1;
            end
            if (reqDone[i]) begin
                last_done_cyc = cyc;
                done_cnt++;
            end
        end
    endtask

    function automatic bit hit(input int what, input int idx);
        case (what)
            0:       return reqAck[idx];
            1:       return reqDone[idx];
            2:       return timeoutErr;
            3:       return (reqValid == '0) && !busy;
            default: return reqAck != '0;
        endcase
    endfunction

    task automatic wait_for(input int what, input int idx, input int budget, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!hit(what, idx) && n < budget);
        if (!hit(what, idx)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_%s: event absent after %0d cycles", nm, budget);
        end
    endtask

    initial begin
        int n;
        int t0;
        reset = 1'b1;
        repeat (2) tick();
        chk("reset_grantId", grantId, 3);
        chk("reset_busy", busy, 0);
        chk("reset_draw", drawerDraw, 0);
        reset = 1'b0;

        set_fields(2, 120, 200, 3);
        draw_len = 50;
        reqValid[2] = 1'b1;
        wait_for(0, 2, 10, "ack2");
        draw_cnt = 0;
        wait_for(1, 2, 100, "done2");
        chk("s1_draw_cycles", draw_cnt, 2);
        chk("s1_done_latency", last_done_cyc - last_ack_cyc, 53);
        chk("s1_x", drawerX, 120);
        chk("s1_y", drawerY, 200);
        chk("s1_rom", drawerROMId, 3);

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_fields(i, 10 * i, 100 + i, i);
        grants.delete();
        draw_len = 3;
        rereq    = '1;
        reqValid = '1;
        n = 0;
        while (grants.size() < 6 && n < 300) begin
            tick();
            n++;
        end
        chk("s3_grant_count", grants.size(), 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("s3_grant%0d", k), (grants.size() > k) ? grants[k] : -1, k % N);
        rereq = '0;
        wait_for(3, 0, 300, "idle3");

        set_fields(3, 10, 300, 7);
        draw_len = 20;
        reqValid[3] = 1'b1;
        wait_for(0, 3, 10, "ack3");
        repeat (8) tick();
        set_fields(1, 55, 66, 9);
        reqValid[1] = 1'b1;
        wait_for(1, 3, 60, "done3");
        t0 = last_done_cyc;
        wait_for(0, 1, 10, "ack1");
        chk("s4_ack_after_done", last_ack_cyc - t0, 1);
        chk("s4_ack_idx", last_ack_idx, 1);
        wait_for(3, 0, 100, "idle4");

        eng_hang = 1'b1;
        set_fields(0, 1, 2, 3);
        reqValid[0] = 1'b1;
        wait_for(0, 0, 10, "ack0");
        draw_cnt = 0;
        done_cnt = 0;
        wait_for(2, 0, 40, "timeout");
        chk("s5_draw_cycles", draw_cnt, 16);
        chk("s5_no_done", done_cnt, 0);
        eng_hang = 1'b0;
        set_fields(2, 200, 511, 15);
        reqValid[2] = 1'b1;
        wait_for(0, 2, 10, "ack2b");
        chk("s5_rearbitrate", last_ack_cyc - terr_cyc, 1);
        wait_for(3, 0, 100, "idle5");

        set_fields(1, 77, 88, 5);
        draw_len = 30;
        reqValid[1] = 1'b1;
        wait_for(0, 1, 10, "ack1b");
        repeat (10) tick();
        chk("s6_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        chk("s6_busy", busy, 0);
        chk("s6_grantId", grantId, 3);
        chk("s6_draw", drawerDraw, 0);
        chk("s6_x", drawerX, 0);
        chk("s6_y", drawerY, 0);
        chk("s6_rom", drawerROMId, 0);
        chk("s6_done", reqDone, 0);
        tick();
        reset = 1'b0;
        set_fields(0, 4, 5, 6);
        set_fields(2, 7, 8, 9);
        reqValid = 4'b0101;
        wait_for(4, 0, 10, "ack_any");
        chk("s6_first_grant", last_ack_idx, 0);
        wait_for(3, 0, 200, "idle6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
